// File: rtl/commit_trace_streamer_if.sv
// Commit-trace streamer bundle: core commit record inputs, framed byte
// stream with valid/ready toward the sink, and status outputs.
//   master : commit producer + byte sink (drives update/record/ready)
//   slave  : the streamer (drives byte_valid/byte_data/empty/overflow/drop_cnt)
interface commit_trace_streamer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             update_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  instr_i;
  logic [4:0]       reg_addr_i;
  logic [XLEN-1:0]  reg_data_i;
  logic             byte_valid_o;
  logic [7:0]       byte_data_o;
  logic             byte_ready_i;
  logic             empty_o;
  logic             overflow_o;
  logic [CNT_W-1:0] drop_cnt_o;

  modport master (
    output update_i, pc_i, instr_i, reg_addr_i, reg_data_i, byte_ready_i,
    input  byte_valid_o, byte_data_o, empty_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  update_i, pc_i, instr_i, reg_addr_i, reg_data_i, byte_ready_i,
    output byte_valid_o, byte_data_o, empty_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/commit_trace_streamer.sv
// Buffers commit records {pc, instr, reg_addr, reg_data} in a FIFO and sends
// each as a framed byte stream: header {3'b101, reg_addr}, pc, instr and,
// when reg_addr != 0, reg_data; each field LSB byte first.
// Ports: clk_i, rst_i (sync, active-high), bus (slave side of
// commit_trace_streamer_if: commit inputs, byte valid/ready/data, empty,
// sticky overflow, saturating drop counter).
module commit_trace_streamer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic                    clk_i,
  input logic                    rst_i,
  commit_trace_streamer_if.slave bus
);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, HDR, PC, INSTR, DATA} state_e;

  state_e              state_q;
  logic [1:0]          idx_q;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                overflow_q;
  logic [CNT_W-1:0]    drop_cnt_q;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [4:0]      rd_mem    [DEPTH];
  logic [XLEN-1:0] data_mem  [DEPTH];

  logic [XLEN-1:0] head_pc, head_instr, head_data;
  logic [4:0]      head_rd;
  logic            hs, last, pop, push, full;
  logic [4:0]      sel;
  logic [7:0]      byte_data;

  assign head_pc    = pc_mem[rd_ptr_q];
  assign head_instr = instr_mem[rd_ptr_q];
  assign head_rd    = rd_mem[rd_ptr_q];
  assign head_data  = data_mem[rd_ptr_q];

  assign hs   = (state_q != IDLE) && bus.byte_ready_i;
  assign last = (idx_q == 2'd3) &&
                (((state_q == INSTR) && (head_rd == 5'd0)) || (state_q == DATA));
  assign pop  = hs && last;
  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full = count_q[PTR_W];
  // A push into a full FIFO is allowed when the head leaves on the same edge;
  // it lands in the slot the head is vacating.
  assign push = bus.update_i && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_BITS'(1);
    else if (pop && !push) count_d = count_q - CNT_BITS'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem[wr_ptr_q]    <= bus.pc_i;
      instr_mem[wr_ptr_q] <= bus.instr_i;
      rd_mem[wr_ptr_q]    <= bus.reg_addr_i;
      data_mem[wr_ptr_q]  <= bus.reg_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (bus.update_i && !push) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        // Leaving IDLE on the push itself puts the header out one cycle later.
        IDLE: if ((count_q != '0) || push) begin
          state_q <= HDR;
          idx_q   <= '0;
        end
        HDR: if (hs) begin
          state_q <= PC;
          idx_q   <= '0;
        end
        PC: if (hs) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= INSTR;
        end
        INSTR: if (hs) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (head_rd != 5'd0)     state_q <= DATA;
            else if (count_d != '0)  state_q <= HDR;
            else                     state_q <= IDLE;
          end
        end
        DATA: if (hs) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= (count_d != '0) ? HDR : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel = {idx_q, 3'b000};

  always_comb begin
    byte_data = '0;
    unique case (state_q)
      HDR:     byte_data = {3'b101, head_rd};
      PC:      byte_data = head_pc[sel +: 8];
      INSTR:   byte_data = head_instr[sel +: 8];
      DATA:    byte_data = head_data[sel +: 8];
      default: byte_data = '0;
    endcase
  end

  assign bus.byte_valid_o = (state_q != IDLE);
  assign bus.byte_data_o  = byte_data;
  assign bus.empty_o      = (count_q == '0) && (state_q == IDLE);
  assign bus.overflow_o   = overflow_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
endmodule
